// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter slice.
// ALU op codes, data width and arbiter state encoding.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

  // Shift amounts of 32 or more flush the operand to zero.
  function automatic logic big_shift(
    input logic [DATA_W-1:0] b
  );
    return |b[DATA_W-1:5];
  endfunction

endpackage

// File: rtl/ALU_32_bit.sv
// Combinational 32-bit ALU: add/sub/and/or/xor/sltu/sll/srl.
// zero flags an all-zero result.
module ALU_32_bit
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alu_control,
  output logic [31:0] result,
  output logic        zero
);

  logic [31:0] w_res;

  always_comb begin
    w_res = '0;
    case (alu_control)
      ALU_ADD: w_res = a + b;
      ALU_SUB: w_res = a - b;
      ALU_AND: w_res = a & b;
      ALU_OR:  w_res = a | b;
      ALU_XOR: w_res = a ^ b;
      ALU_SLT: w_res = {31'd0, a < b};
      ALU_SLL: w_res = big_shift(b) ? '0 : a << b[4:0];
      ALU_SRL: w_res = big_shift(b) ? '0 : a >> b[4:0];
      default: w_res = '0;
    endcase
  end

  assign result = w_res;
  assign zero   = (w_res == '0);

endmodule

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant from request valids and last grant.
// Purely combinational; at most one grant bit is set.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters.
// Round-robin issue, registered result held until the owner accepts.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OP_W       = 3,
  parameter int FIRST_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [DATA_W-1:0] r0_a,
  input  logic [DATA_W-1:0] r0_b,
  input  logic [OP_W-1:0]   r0_op,
  output logic              r0_resp_valid,
  input  logic              r0_resp_ready,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [DATA_W-1:0] r1_a,
  input  logic [DATA_W-1:0] r1_b,
  input  logic [OP_W-1:0]   r1_op,
  output logic              r1_resp_valid,
  input  logic              r1_resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic LAST_INIT = (FIRST_PRIO == 0);

  arb_state_e        r_state;
  logic              r_owner;
  logic              r_last;
  logic [DATA_W-1:0] r_result;
  logic              r_zero;
  logic [CNT_W-1:0]  r_count;

  logic [1:0]        w_valid;
  logic [1:0]        w_grant;
  logic              w_hold;
  logic              w_fire;
  logic              w_can;
  logic              w_issue;
  logic              w_sel;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [OP_W-1:0]   w_op;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_zero;

  assign w_valid = {r1_req_valid, r0_req_valid};

  rr_arb2 u_arb (
    .i_valid (w_valid),
    .i_last  (r_last),
    .o_grant (w_grant)
  );

  assign w_hold = (r_state == ARB_HOLD);
  assign w_fire = w_hold
                & (r_owner ? r1_resp_ready : r0_resp_ready);

  // Acceptance in the same cycle frees the slot for a new issue.
  assign w_can  = ~reset & (~w_hold | w_fire);

  assign r0_req_ready = w_can & w_grant[0];
  assign r1_req_ready = w_can & w_grant[1];
  assign w_issue      = r0_req_ready | r1_req_ready;

  assign w_sel = w_grant[1];
  assign w_a   = w_sel ? r1_a  : r0_a;
  assign w_b   = w_sel ? r1_b  : r0_b;
  assign w_op  = w_sel ? r1_op : r0_op;

  ALU_32_bit u_alu (
    .a           (w_a),
    .b           (w_b),
    .alu_control (w_op),
    .result      (w_alu_res),
    .zero        (w_alu_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_owner  <= 1'b0;
      r_last   <= LAST_INIT;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_fire) begin
        r_count <= r_count + 1'b1;
      end
      if (w_issue) begin
        r_state  <= ARB_HOLD;
        r_owner  <= w_sel;
        r_last   <= w_sel;
        r_result <= w_alu_res;
        r_zero   <= w_alu_zero;
      end else if (w_fire) begin
        r_state <= ARB_IDLE;
      end
    end
  end

  assign r0_resp_valid = w_hold & ~r_owner;
  assign r1_resp_valid = w_hold &  r_owner;
  assign resp_result   = r_result;
  assign resp_zero     = r_zero;
  assign op_count      = r_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a cycle-level reference model.
// Model tracks the pending response abstractly; compare runs each negedge.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        r0_req_valid = 1'b0;
  logic        r0_req_ready;
  logic [31:0] r0_a = '0;
  logic [31:0] r0_b = '0;
  logic [2:0]  r0_op = '0;
  logic        r0_resp_valid;
  logic        r0_resp_ready = 1'b0;
  logic        r1_req_valid = 1'b0;
  logic        r1_req_ready;
  logic [31:0] r1_a = '0;
  logic [31:0] r1_b = '0;
  logic [2:0]  r1_op = '0;
  logic        r1_resp_valid;
  logic        r1_resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic        resp_zero;
  logic [15:0] op_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(
    .DATA_W(32), .OP_W(3), .FIRST_PRIO(0), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready),
    .r0_a(r0_a), .r0_b(r0_b), .r0_op(r0_op),
    .r0_resp_valid(r0_resp_valid), .r0_resp_ready(r0_resp_ready),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready),
    .r1_a(r1_a), .r1_b(r1_b), .r1_op(r1_op),
    .r1_resp_valid(r1_resp_valid), .r1_resp_ready(r1_resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .op_count(op_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] alu_model(input logic [2:0] op,
    input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (a < b) ? 32'd1 : 32'd0;
      3'd6:    return a << b;
      default: return a >> b;
    endcase
  endfunction

  // Pending response: present flag, owner, value, zero; plus fairness pointer.
  logic        m_has = 1'b0;
  logic        m_who = 1'b0;
  logic [31:0] m_val = '0;
  logic        m_zero = 1'b0;
  logic        m_last = 1'b1;
  logic [15:0] m_cnt = '0;

  function automatic logic [1:0] exp_ready(input logic rst,
    input logic has, input logic who, input logic last,
    input logic v0, input logic v1, input logic a0, input logic a1);
    logic taken;
    if (rst) return 2'b00;
    taken = has && (who ? a1 : a0);
    if (has && !taken) return 2'b00;
    if (v0 && v1) return last ? 2'b01 : 2'b10;
    if (v0) return 2'b01;
    if (v1) return 2'b10;
    return 2'b00;
  endfunction

  logic [1:0] e_rdy;
  logic       e_fire;
  assign e_rdy = exp_ready(reset, m_has, m_who, m_last,
                           r0_req_valid, r1_req_valid,
                           r0_resp_ready, r1_resp_ready);
  assign e_fire = m_has && (m_who ? r1_resp_ready : r0_resp_ready);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_has  <= 1'b0;
      m_who  <= 1'b0;
      m_val  <= '0;
      m_zero <= 1'b0;
      m_last <= 1'b1;
      m_cnt  <= '0;
    end else begin
      if (e_fire) m_cnt <= m_cnt + 16'd1;
      if (e_rdy != 2'b00) begin
        m_has  <= 1'b1;
        m_who  <= e_rdy[1];
        m_last <= e_rdy[1];
        m_val  <= e_rdy[1] ? alu_model(r1_op, r1_a, r1_b)
                           : alu_model(r0_op, r0_a, r0_b);
        m_zero <= (e_rdy[1] ? alu_model(r1_op, r1_a, r1_b)
                            : alu_model(r0_op, r0_a, r0_b)) == 32'd0;
      end else if (e_fire) begin
        m_has <= 1'b0;
      end
    end
  end

  int grants[$];

  always @(negedge clk) begin
    chk("r0_req_ready", {31'd0, r0_req_ready}, {31'd0, e_rdy[0]});
    chk("r1_req_ready", {31'd0, r1_req_ready}, {31'd0, e_rdy[1]});
    chk("r0_resp_valid", {31'd0, r0_resp_valid},
        {31'd0, m_has && !m_who});
    chk("r1_resp_valid", {31'd0, r1_resp_valid},
        {31'd0, m_has && m_who});
    chk("resp_result", resp_result, m_val);
    chk("resp_zero", {31'd0, resp_zero}, {31'd0, m_zero});
    chk("op_count", {16'd0, op_count}, {16'd0, m_cnt});
    if (!reset && r0_req_ready && r0_req_valid) grants.push_back(0);
    if (!reset && r1_req_ready && r1_req_valid) grants.push_back(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    tick();
  endtask

  initial begin
    int alt_ok;
    int n0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    tick();

    @(negedge clk);
    chk("reset op_count", {16'd0, op_count}, 32'd0);
    chk("reset resp_valid", {30'd0, r1_resp_valid, r0_resp_valid}, 32'd0);
    chk("reset result", resp_result, 32'd0);

    // single add
    tick();
    r0_req_valid = 1'b1; r0_a = 32'd5; r0_b = 32'd7; r0_op = 3'd0;
    @(negedge clk);
    chk("single ready", {31'd0, r0_req_ready}, 32'd1);
    tick();
    r0_req_valid = 1'b0;
    @(negedge clk);
    chk("single valid", {31'd0, r0_resp_valid}, 32'd1);
    chk("single result", resp_result, 32'd12);
    chk("single zero", {31'd0, resp_zero}, 32'd0);
    tick();
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b1;
    tick();

    // contention from fresh reset
    do_reset();
    r0_req_valid = 1'b1; r0_a = 32'd3; r0_b = 32'd3; r0_op = 3'd1;
    r1_req_valid = 1'b1; r1_a = 32'hF0; r1_b = 32'h0F; r1_op = 3'd3;
    @(negedge clk);
    chk("cont r0 first", {30'd0, r1_req_ready, r0_req_ready}, 32'd1);
    tick();
    r0_req_valid = 1'b0;
    @(negedge clk);
    chk("cont r0 result", resp_result, 32'd0);
    chk("cont r0 zero", {31'd0, resp_zero}, 32'd1);
    chk("cont r1 next", {31'd0, r1_req_ready}, 32'd1);
    tick();
    r1_req_valid = 1'b0;
    @(negedge clk);
    chk("cont r1 valid", {31'd0, r1_resp_valid}, 32'd1);
    chk("cont r1 result", resp_result, 32'hFF);
    tick();
    @(negedge clk);
    chk("cont op_count", {16'd0, op_count}, 32'd2);

    // backpressure on r1 while r0 waits
    tick();
    r1_resp_ready = 1'b0;
    r1_req_valid = 1'b1; r1_a = 32'd2; r1_b = 32'hFFFF_FFFF; r1_op = 3'd5;
    @(negedge clk);
    chk("bp r1 ready", {31'd0, r1_req_ready}, 32'd1);
    tick();
    r1_req_valid = 1'b0;
    r0_req_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd1; r0_op = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp held result", resp_result, 32'd1);
      chk("bp r0 blocked", {31'd0, r0_req_ready}, 32'd0);
      chk("bp r1 pending", {31'd0, r1_resp_valid}, 32'd1);
      if (i < 2) tick();
    end
    tick();
    r1_resp_ready = 1'b1;
    @(negedge clk);
    chk("bp r0 same cycle", {31'd0, r0_req_ready}, 32'd1);
    tick();
    r0_req_valid = 1'b0;
    @(negedge clk);
    chk("bp r0 result", resp_result, 32'd2);
    tick();

    // shift and wrap boundaries, back to back
    r0_req_valid = 1'b1; r0_a = 32'd1; r0_b = 32'd31; r0_op = 3'd6;
    @(negedge clk);
    tick();
    r0_a = 32'h8000_0000; r0_b = 32'd32; r0_op = 3'd7;
    @(negedge clk);
    chk("sll 31", resp_result, 32'h8000_0000);
    tick();
    r0_a = 32'hFFFF_FFFF; r0_b = 32'd1; r0_op = 3'd0;
    @(negedge clk);
    chk("srl 32", resp_result, 32'd0);
    chk("srl 32 zero", {31'd0, resp_zero}, 32'd1);
    tick();
    r0_req_valid = 1'b0;
    @(negedge clk);
    chk("add wrap", resp_result, 32'd0);
    chk("add wrap zero", {31'd0, resp_zero}, 32'd1);
    tick();

    // fairness: both valid for ten issues
    r0_req_valid = 1'b1; r0_a = 32'd9; r0_b = 32'd4; r0_op = 3'd1;
    r1_req_valid = 1'b1; r1_a = 32'hAA; r1_b = 32'h55; r1_op = 3'd4;
    grants.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tick();
    end
    r0_req_valid = 1'b0;
    r1_req_valid = 1'b0;
    @(negedge clk);
    alt_ok = 1;
    n0 = 0;
    foreach (grants[i]) begin
      if (grants[i] == 0) n0++;
      if (i > 0 && grants[i] == grants[i-1]) alt_ok = 0;
    end
    chk("fair issues", grants.size(), 32'd10);
    chk("fair alternate", alt_ok, 32'd1);
    chk("fair r0 count", n0, 32'd5);
    if (grants.size() > 0) chk("fair first r1", grants[0], 32'd1);
    tick();

    // reset while holding a result
    r0_resp_ready = 1'b0;
    r0_req_valid = 1'b1; r0_a = 32'd6; r0_b = 32'd3; r0_op = 3'd2;
    @(negedge clk);
    tick();
    r0_req_valid = 1'b0;
    @(negedge clk);
    chk("hold before rst", {31'd0, r0_resp_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst async valid", {31'd0, r0_resp_valid}, 32'd0);
    chk("rst op_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    r0_resp_ready = 1'b1;
    tick();
    r1_req_valid = 1'b1; r1_a = 32'd10; r1_b = 32'd20; r1_op = 3'd0;
    @(negedge clk);
    chk("post rst r1 ready", {31'd0, r1_req_ready}, 32'd1);
    tick();
    r1_req_valid = 1'b0;
    @(negedge clk);
    chk("post rst r1 valid", {31'd0, r1_resp_valid}, 32'd1);
    chk("post rst result", resp_result, 32'd30);
    chk("post rst r0 none", {31'd0, r0_resp_valid}, 32'd0);
    tick();
    @(negedge clk);
    chk("post rst count", {16'd0, op_count}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 32-bit ALU (ALU_32_bit, instantiated inside) between two requesters, e.g. the integer execute path and an address/branch helper.
- Each requester uses a valid/ready handshake on the request side and a valid/ready handshake on the response side.
- A round-robin arbiter picks at most one request per cycle, and the ALU result is registered.
- The result is held until the owning requester accepts it. Throughput is one operation per cycle when responses are accepted immediately.

Parameters:
- DATA_W, 32: operand and result width. Fixed at 32 to match the ALU; other values are unsupported.
- OP_W, 3: alu_control width.
- FIRST_PRIO, 0: requester that wins the first contended arbitration after reset (0 or 1).
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- r0_req_valid, in, 1: requester 0 has an operation.
- r0_req_ready, out, 1: requester 0 operation accepted this cycle.
- r0_a, in, 32: requester 0 operand a.
- r0_b, in, 32: requester 0 operand b.
- r0_op, in, 3: requester 0 alu_control code.
- r0_resp_valid, out, 1: result pending for requester 0.
- r0_resp_ready, in, 1: requester 0 takes the result.
- r1_req_valid, r1_req_ready, r1_a, r1_b, r1_op, r1_resp_valid, r1_resp_ready: identical to the r0_ ports, for requester 1.
- resp_result, out, 32: registered ALU result, shared by both requesters and qualified by rN_resp_valid.
- resp_zero, out, 1: registered zero flag.
- op_count, out, CNT_W: number of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- State machine has two states: IDLE (no result held) and HOLD (result held for the requester in register owner).
- can_issue = (state==IDLE) | (state==HOLD & resp_fire).
- resp_fire = rOwner_resp_valid & rOwner_resp_ready.
- Arbitration is recomputed every cycle from the current req_valid values; no lock is held while waiting:
  - only one valid requester: it wins;
  - both valid: the requester that is not last_grant wins;
  - rN_req_ready = can_issue & win_N, driven combinationally.
- rN_req_ready depends combinationally on rN_resp_ready. This path is intentional; requesters must not derive resp_ready from req_ready.
- On issue (the winner's valid & ready):
  - winner's a, b, op are driven into the ALU;
  - result and zero flag are registered into resp_result and resp_zero;
  - owner and last_grant are set to the winner;
  - next state is HOLD.
- Latency: response is visible the cycle after acceptance. A response accepted in cycle N allows a new issue in cycle N, so back-to-back operations run at 1 per cycle.
- HOLD with no resp_fire: resp_result, resp_zero and owner stay stable. All req_ready are 0.
- HOLD with resp_fire and no new issue: next state is IDLE; rN_resp_valid deasserts next cycle.
- op_count increments on every resp_fire.
- ALU semantics, per code:
  - 000: add, wraps mod 2^32;
  - 001: sub, wraps mod 2^32;
  - 010: and;
  - 011: or;
  - 100: xor;
  - 101: unsigned set-less-than, result 1 or 0;
  - 110: sll by the full b value; b>=32 gives 0;
  - 111: srl by the full b value; b>=32 gives 0;
  - zero = (result == 0).
- All 8 op codes are legal; there is no error path.
- Requesters must hold a, b, op stable while valid and not ready. A requester may drop valid before it is granted; the arbiter simply re-evaluates.
- Reset values:
  - state=IDLE;
  - owner=0;
  - last_grant = ~FIRST_PRIO;
  - resp_result=0, resp_zero=0, op_count=0;
  - all rN_resp_valid=0 and all rN_req_ready=0 while reset is asserted.
- Reset asserted mid-HOLD discards the pending result; no response is ever delivered for it.

Decomposition:
- Shared package alu_pkg holds:
  - ALU op codes ALU_ADD..ALU_SRL (000..111);
  - DATA_W;
  - state enum {ARB_IDLE, ARB_HOLD}.
- Natural sub-module: rr_arb2 (2-way round-robin grant from valids plus last_grant; combinational).
- The ALU itself is the existing ALU_32_bit instance, unmodified.

Test Plan:
- Single op. After reset, r0 requests add, a=5, b=7. Required: r0_req_ready=1 that cycle; next cycle r0_resp_valid=1, resp_result=12, resp_zero=0.
- Contention.
  - Both request from IDLE, FIRST_PRIO=0: r0 sub 3-3, r1 or 0xF0|0x0F.
  - resp_ready is held at 1 throughout.
  - Required: r0 granted first, result 0 and zero=1; r1 granted the next cycle, result 0xFF. Issues occur on consecutive cycles and op_count=2.
- Backpressure.
  - r1 slt a=2, b=0xFFFFFFFF, with r1_resp_ready=0 for 3 cycles; r0 is valid meanwhile.
  - Required: result 1 held stable, r0_req_ready=0 throughout.
  - When r1_resp_ready rises, r0 is granted in that same cycle.
- Shift boundary: sll a=1, b=31 -> 0x80000000; srl a=0x80000000, b=32 -> 0 with zero=1; add 0xFFFFFFFF+1 -> 0 with zero=1.
- Fairness: both requesters valid continuously for 10 issues with resp_ready=1. Required: grants strictly alternate, 5 each.
- Reset mid-op: assert reset while in HOLD. Required: resp_valid falls immediately (async), op_count=0; after release, a fresh r1 request completes normally.
